alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage_pkg.sv | 40 ++++
 rtl/alu_issue_stage_if.sv | 45 ++++
 rtl/alu_issue_stage_ctrl_decode.sv | 65 ++++++
 rtl/alu_issue_stage.sv | 127 ++++++++++++
 tb/tb_alu_issue_stage.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared constants for the ALU issue stage: datapath width, MIPS opcode/funct
// encodings and the EX-stage ALU control codes.
package alu_issue_stage_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [3:0] {
    EXE_NO_OPERATION = 4'd0,
    EXE_ADD          = 4'd1,
    EXE_SUB          = 4'd2,
    EXE_AND          = 4'd3,
    EXE_OR           = 4'd4,
    EXE_NOR          = 4'd5,
    EXE_SLT          = 4'd6,
    EXE_SLL          = 4'd7,
    EXE_SRL          = 4'd8
  } alu_ctrl_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID-to-EX bundle of the ALU issue stage: decoded fields, register data,
// bypass sources, pipeline control and the registered EX-stage outputs.
interface alu_issue_stage_if #(parameter int WIDTH = 32);

  logic             stall;
  logic             flush;
  logic             valid_id;
  logic [5:0]       opcode_id;
  logic [5:0]       funct_id;
  logic [4:0]       shamt_id;
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic [15:0]      imm_id;
  logic [WIDTH-1:0] rs_data_id;
  logic [WIDTH-1:0] rt_data_id;

  logic             fwd_mem_en;
  logic             fwd_wb_en;
  logic [4:0]       fwd_mem_rd;
  logic [4:0]       fwd_wb_rd;
  logic [WIDTH-1:0] fwd_mem_data;
  logic [WIDTH-1:0] fwd_wb_data;

  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic [4:0]       shamt_exe;
  logic [3:0]       alucontrol_exe;
  logic             valid_exe;
  logic             illegal_exe;

  modport master (
    output stall, flush, valid_id, opcode_id, funct_id, shamt_id, rs_id, rt_id,
           imm_id, rs_data_id, rt_data_id, fwd_mem_en, fwd_wb_en, fwd_mem_rd,
           fwd_wb_rd, fwd_mem_data, fwd_wb_data,
    input  val1, val2, shamt_exe, alucontrol_exe, valid_exe, illegal_exe
  );

  modport slave (
    input  stall, flush, valid_id, opcode_id, funct_id, shamt_id, rs_id, rt_id,
           imm_id, rs_data_id, rt_data_id, fwd_mem_en, fwd_wb_en, fwd_mem_rd,
           fwd_wb_rd, fwd_mem_data, fwd_wb_data,
    output val1, val2, shamt_exe, alucontrol_exe, valid_exe, illegal_exe
  );

endinterface

// File: rtl/alu_issue_stage_ctrl_decode.sv
// Combinational opcode/funct decode: ALU control, immediate select and
// extension mode, shift flag, and an unrecognised-encoding flag.
module alu_ctrl_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output alu_ctrl_e  alucontrol_o,
  output logic       imm_sel_o,
  output logic       imm_sext_o,
  output logic       shift_o,
  output logic       illegal_o
);

  always_comb begin
    alucontrol_o = EXE_NO_OPERATION;
    imm_sel_o    = 1'b0;
    imm_sext_o   = 1'b0;
    shift_o      = 1'b0;
    illegal_o    = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD, FN_ADDU: alucontrol_o = EXE_ADD;
          FN_SUB, FN_SUBU: alucontrol_o = EXE_SUB;
          FN_AND:          alucontrol_o = EXE_AND;
          FN_OR:           alucontrol_o = EXE_OR;
          FN_NOR:          alucontrol_o = EXE_NOR;
          FN_SLT:          alucontrol_o = EXE_SLT;
          FN_SLL: begin
            alucontrol_o = EXE_SLL;
            shift_o      = 1'b1;
          end
          FN_SRL: begin
            alucontrol_o = EXE_SRL;
            shift_o      = 1'b1;
          end
          default:         illegal_o = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        alucontrol_o = EXE_ADD;
        imm_sel_o    = 1'b1;
        imm_sext_o   = 1'b1;
      end
      OP_SLTI: begin
        alucontrol_o = EXE_SLT;
        imm_sel_o    = 1'b1;
        imm_sext_o   = 1'b1;
      end
      OP_ANDI: begin
        alucontrol_o = EXE_AND;
        imm_sel_o    = 1'b1;
      end
      OP_ORI: begin
        alucontrol_o = EXE_OR;
        imm_sel_o    = 1'b1;
      end
      // beq compares rs against rt, so it keeps the register operand
      OP_BEQ:  alucontrol_o = EXE_SUB;
      default: illegal_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// EX-stage issue register with optional operand bypass (macro ALU_FWD_EN); 1-cycle latency.
// stall holds the register; rst, flush, or an idle ID slot loads a bubble.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_stage_if.slave    bus
);

  alu_ctrl_e        dec_ctrl;
  logic             dec_imm_sel;
  logic             dec_imm_sext;
  logic             dec_shift;
  logic             dec_illegal;

  logic [WIDTH-1:0] rs_op;
  logic [WIDTH-1:0] rt_op;
  logic [WIDTH-1:0] imm_ext;
  logic             nop_word;

  logic [WIDTH-1:0] val1_d, val1_q;
  logic [WIDTH-1:0] val2_d, val2_q;
  logic [4:0]       shamt_d, shamt_q;
  logic [3:0]       ctrl_d, ctrl_q;
  logic             illegal_d, illegal_q;
  logic             valid_q;

  alu_ctrl_decode u_decode (
    .opcode_i     (bus.opcode_id),
    .funct_i      (bus.funct_id),
    .alucontrol_o (dec_ctrl),
    .imm_sel_o    (dec_imm_sel),
    .imm_sext_o   (dec_imm_sext),
    .shift_o      (dec_shift),
    .illegal_o    (dec_illegal)
  );

`ifdef ALU_FWD_EN
  function automatic logic [WIDTH-1:0] bypass(
    input logic [4:0]       src,
    input logic [WIDTH-1:0] rf_data,
    input logic             mem_en,
    input logic [4:0]       mem_rd,
    input logic [WIDTH-1:0] mem_data,
    input logic             wb_en,
    input logic [4:0]       wb_rd,
    input logic [WIDTH-1:0] wb_data
  );
    logic [WIDTH-1:0] res;
    res = rf_data;
    if (src != 5'd0) begin
      if (mem_en && (mem_rd == src))
        res = mem_data;
      else if (wb_en && (wb_rd == src))
        res = wb_data;
    end
    return res;
  endfunction

  assign rs_op = bypass(bus.rs_id, bus.rs_data_id, bus.fwd_mem_en, bus.fwd_mem_rd,
                        bus.fwd_mem_data, bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_data);
  assign rt_op = bypass(bus.rt_id, bus.rt_data_id, bus.fwd_mem_en, bus.fwd_mem_rd,
                        bus.fwd_mem_data, bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.fwd_mem_en, bus.fwd_wb_en, bus.fwd_mem_rd, bus.fwd_wb_rd,
                        bus.fwd_mem_data, bus.fwd_wb_data};
  assign rs_op = bus.rs_data_id;
  assign rt_op = bus.rt_data_id;
`endif

  assign imm_ext  = dec_imm_sext ? {{(WIDTH-16){bus.imm_id[15]}}, bus.imm_id}
                                 : {{(WIDTH-16){1'b0}}, bus.imm_id};
  // The canonical all-zero word is the architectural nop, not an SLL
  assign nop_word = (bus.opcode_id == 6'd0) && (bus.funct_id == 6'd0) &&
                    (bus.shamt_id == 5'd0) && (bus.rs_id == 5'd0) && (bus.rt_id == 5'd0);

  always_comb begin
    val1_d    = '0;
    val2_d    = '0;
    shamt_d   = '0;
    ctrl_d    = EXE_NO_OPERATION;
    illegal_d = 1'b0;
    if (nop_word) begin
      ctrl_d = EXE_NO_OPERATION;
    end else if (dec_illegal) begin
      illegal_d = bus.valid_id;
    end else if (dec_shift) begin
      ctrl_d  = dec_ctrl;
      val1_d  = rt_op;
      shamt_d = bus.shamt_id;
    end else begin
      ctrl_d = dec_ctrl;
      val1_d = rs_op;
      val2_d = dec_imm_sel ? imm_ext : rt_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush || (!bus.stall && !bus.valid_id)) begin
      val1_q    <= '0;
      val2_q    <= '0;
      shamt_q   <= '0;
      ctrl_q    <= EXE_NO_OPERATION;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (!bus.stall) begin
      val1_q    <= val1_d;
      val2_q    <= val2_d;
      shamt_q   <= shamt_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= 1'b1;
      illegal_q <= illegal_d;
    end
  end

  assign bus.val1           = val1_q;
  assign bus.val2           = val2_q;
  assign bus.shamt_exe      = shamt_q;
  assign bus.alucontrol_exe = ctrl_q;
  assign bus.valid_exe      = valid_q;
  assign bus.illegal_exe    = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic checked
// against an instruction-level reference of the EX register.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] v1;
    logic [W-1:0] v2;
    logic [4:0]   sh;
    logic [3:0]   ctl;
    logic         vld;
    logic         ill;
  } ex_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.WIDTH(W)) bus ();

  alu_issue_stage #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  ex_t  model;
  ex_t  snap;

  logic [5:0] legal_ops [0:8] = '{6'b000000, 6'b000000, 6'b001000, 6'b001001, 6'b100011,
                                  6'b101011, 6'b001010, 6'b001100, 6'b001101};
  logic [5:0] legal_fns [0:9] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                  6'b100101, 6'b100111, 6'b101010, 6'b000000, 6'b000010};

  function automatic ex_t bubble();
    ex_t e;
    e = '0;
    e.ctl = EXE_NO_OPERATION;
    return e;
  endfunction

  function automatic ex_t observed();
    return {bus.val1, bus.val2, bus.shamt_exe, bus.alucontrol_exe, bus.valid_exe, bus.illegal_exe};
  endfunction

  function automatic logic [W-1:0] operand(input logic [4:0] r, input logic [W-1:0] rf);
`ifdef ALU_FWD_EN
    if (r != 0 && bus.fwd_mem_en && bus.fwd_mem_rd == r) return bus.fwd_mem_data;
    if (r != 0 && bus.fwd_wb_en && bus.fwd_wb_rd == r) return bus.fwd_wb_data;
`endif
    return rf;
  endfunction

  // What an instruction in the ID slot should place into EX
  function automatic ex_t issue_ref();
    ex_t e;
    logic [W-1:0] a, b, sx, zx;
    e = bubble();
    e.vld = 1'b1;
    a  = operand(bus.rs_id, bus.rs_data_id);
    b  = operand(bus.rt_id, bus.rt_data_id);
    sx = {{16{bus.imm_id[15]}}, bus.imm_id};
    zx = {16'h0000, bus.imm_id};
    if ({bus.opcode_id, bus.funct_id, bus.shamt_id, bus.rs_id, bus.rt_id} == 0) return e;
    if (bus.opcode_id == 6'b000000) begin
      case (bus.funct_id)
        6'b100000, 6'b100001: begin e.ctl = EXE_ADD; e.v1 = a; e.v2 = b; end
        6'b100010, 6'b100011: begin e.ctl = EXE_SUB; e.v1 = a; e.v2 = b; end
        6'b100100:            begin e.ctl = EXE_AND; e.v1 = a; e.v2 = b; end
        6'b100101:            begin e.ctl = EXE_OR;  e.v1 = a; e.v2 = b; end
        6'b100111:            begin e.ctl = EXE_NOR; e.v1 = a; e.v2 = b; end
        6'b101010:            begin e.ctl = EXE_SLT; e.v1 = a; e.v2 = b; end
        6'b000000:            begin e.ctl = EXE_SLL; e.v1 = b; e.sh = bus.shamt_id; end
        6'b000010:            begin e.ctl = EXE_SRL; e.v1 = b; e.sh = bus.shamt_id; end
        default:              e.ill = 1'b1;
      endcase
    end else begin
      case (bus.opcode_id)
        6'b001000, 6'b001001, 6'b100011, 6'b101011: begin e.ctl = EXE_ADD; e.v1 = a; e.v2 = sx; end
        6'b001010: begin e.ctl = EXE_SLT; e.v1 = a; e.v2 = sx; end
        6'b001100: begin e.ctl = EXE_AND; e.v1 = a; e.v2 = zx; end
        6'b001101: begin e.ctl = EXE_OR;  e.v1 = a; e.v2 = zx; end
        6'b000100: begin e.ctl = EXE_SUB; e.v1 = a; e.v2 = b; end
        default:   e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic ex_t next_ref();
    if (rst || bus.flush) return bubble();
    if (bus.stall) return model;
    if (!bus.valid_id) return bubble();
    return issue_ref();
  endfunction

  task automatic tick();
    ex_t nxt;
    nxt = next_ref();
    @(posedge clk);
    #1;
    model = nxt;
  endtask

  task automatic drive_idle();
    bus.stall = 0; bus.flush = 0; bus.valid_id = 0;
    bus.opcode_id = 0; bus.funct_id = 0; bus.shamt_id = 0; bus.rs_id = 0; bus.rt_id = 0;
    bus.imm_id = 0; bus.rs_data_id = 0; bus.rt_data_id = 0;
    bus.fwd_mem_en = 0; bus.fwd_wb_en = 0; bus.fwd_mem_rd = 0; bus.fwd_wb_rd = 0;
    bus.fwd_mem_data = 0; bus.fwd_wb_data = 0;
  endtask

  task automatic rand_instr();
    bus.valid_id   = 1'b1;
    bus.opcode_id  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 8)];
    bus.funct_id   = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 9)];
    bus.shamt_id   = 5'($urandom);
    bus.rs_id      = 5'($urandom_range(0, 7));
    bus.rt_id      = 5'($urandom_range(0, 7));
    bus.imm_id     = 16'($urandom);
    bus.rs_data_id = $urandom;
    bus.rt_data_id = $urandom;
    bus.fwd_mem_en = 1'($urandom); bus.fwd_mem_rd = 5'($urandom_range(0, 7));
    bus.fwd_wb_en  = 1'($urandom); bus.fwd_wb_rd  = 5'($urandom_range(0, 7));
    bus.fwd_mem_data = $urandom;   bus.fwd_wb_data = $urandom;
  endtask

  task automatic test_reset();
    rand_instr();
    rst = 1'b1; bus.stall = 1'b1;
    tick();
    checks++;
    if (observed() !== bubble() || model !== bubble()) begin
      errors++; $display("FAIL reset_bubble: got %h want %h", observed(), bubble());
    end
    rst = 1'b0; drive_idle();
    tick();
    checks++;
    if (observed() !== bubble()) begin
      errors++; $display("FAIL first_edge_idle: got %h want %h", observed(), bubble());
    end
  endtask

  task automatic test_add();
    drive_idle();
    bus.valid_id = 1; bus.funct_id = 6'b100000; bus.rs_id = 5; bus.rt_id = 6;
    bus.rs_data_id = 7; bus.rt_data_id = 3; bus.shamt_id = 0;
    tick();
    checks++;
    if (bus.val1 !== 32'd7 || bus.val2 !== 32'd3 || bus.alucontrol_exe !== EXE_ADD ||
        bus.valid_exe !== 1'b1 || bus.illegal_exe !== 1'b0) begin
      errors++;
      $display("FAIL add: got v1=%0d v2=%0d ctl=%0d vld=%b want 7 3 %0d 1",
               bus.val1, bus.val2, bus.alucontrol_exe, bus.valid_exe, EXE_ADD);
    end
    bus.funct_id = 6'b000010; bus.shamt_id = 5'd9;
    tick();
    checks++;
    if (bus.val1 !== 32'd3 || bus.val2 !== 32'd0 || bus.shamt_exe !== 5'd9 ||
        bus.alucontrol_exe !== EXE_SRL) begin
      errors++;
      $display("FAIL srl: got v1=%0d v2=%0d sh=%0d ctl=%0d want 3 0 9 %0d",
               bus.val1, bus.val2, bus.shamt_exe, bus.alucontrol_exe, EXE_SRL);
    end
  endtask

  task automatic test_imm();
    drive_idle();
    bus.valid_id = 1; bus.opcode_id = 6'b001000; bus.rs_id = 2; bus.rs_data_id = 32'h10;
    bus.imm_id = 16'hFFFF;
    tick();
    checks++;
    if (bus.val2 !== 32'hFFFFFFFF || bus.val1 !== 32'h10 || bus.alucontrol_exe !== EXE_ADD) begin
      errors++; $display("FAIL addi_sext: got v2=%h ctl=%0d want ffffffff %0d",
                         bus.val2, bus.alucontrol_exe, EXE_ADD);
    end
    bus.opcode_id = 6'b001101;
    tick();
    checks++;
    if (bus.val2 !== 32'h0000FFFF || bus.alucontrol_exe !== EXE_OR) begin
      errors++; $display("FAIL ori_zext: got v2=%h ctl=%0d want 0000ffff %0d",
                         bus.val2, bus.alucontrol_exe, EXE_OR);
    end
  endtask

  task automatic test_fwd();
    drive_idle();
    bus.valid_id = 1; bus.funct_id = 6'b100000; bus.rs_id = 4; bus.rt_id = 1;
    bus.rs_data_id = 99; bus.rt_data_id = 5;
    bus.fwd_mem_en = 1; bus.fwd_mem_rd = 4; bus.fwd_mem_data = 11;
    bus.fwd_wb_en  = 1; bus.fwd_wb_rd  = 4; bus.fwd_wb_data  = 22;
    tick();
    checks++;
`ifdef ALU_FWD_EN
    if (bus.val1 !== 32'd11) begin
      errors++; $display("FAIL fwd_mem_priority: got %0d want 11", bus.val1);
    end
`else
    if (bus.val1 !== 32'd99) begin
      errors++; $display("FAIL fwd_ignored: got %0d want 99", bus.val1);
    end
`endif
    bus.fwd_mem_en = 0;
    tick();
    checks++;
    if (observed() !== model) begin
      errors++; $display("FAIL fwd_wb: got %h want %h", observed(), model);
    end
    bus.rs_id = 0; bus.fwd_mem_en = 1; bus.fwd_mem_rd = 0; bus.fwd_wb_rd = 0;
    tick();
    checks++;
    if (bus.val1 !== 32'd99) begin
      errors++; $display("FAIL fwd_r0: got %0d want 99", bus.val1);
    end
  endtask

  task automatic test_stall_flush();
    drive_idle();
    bus.valid_id = 1; bus.funct_id = 6'b100100; bus.rs_id = 3; bus.rt_id = 7;
    bus.rs_data_id = 32'hA5A5_0001; bus.rt_data_id = 32'h0F0F_0002;
    tick();
    snap = observed();
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1; rand_instr();
      tick();
      checks++;
      if (observed() !== snap || model !== snap) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h want %h", i, observed(), snap);
      end
    end
    bus.flush = 1;
    tick();
    checks++;
    if (observed() !== bubble()) begin
      errors++; $display("FAIL stall_flush: got %h want %h", observed(), bubble());
    end
    drive_idle();
  endtask

  task automatic test_illegal();
    drive_idle();
    bus.valid_id = 1; bus.opcode_id = 6'b111111; bus.rs_id = 1; bus.rs_data_id = 5;
    tick();
    checks++;
    if (bus.alucontrol_exe !== EXE_NO_OPERATION || bus.illegal_exe !== 1'b1 || bus.valid_exe !== 1'b1) begin
      errors++; $display("FAIL illegal_op: got ctl=%0d ill=%b vld=%b want 0 1 1",
                         bus.alucontrol_exe, bus.illegal_exe, bus.valid_exe);
    end
    bus.opcode_id = 0; bus.funct_id = 6'b111111;
    tick();
    checks++;
    if (bus.alucontrol_exe !== EXE_NO_OPERATION || bus.illegal_exe !== 1'b1) begin
      errors++; $display("FAIL illegal_funct: got ctl=%0d ill=%b want 0 1",
                         bus.alucontrol_exe, bus.illegal_exe);
    end
    drive_idle(); bus.valid_id = 1;
    tick();
    checks++;
    if (bus.alucontrol_exe !== EXE_NO_OPERATION || bus.illegal_exe !== 1'b0 || bus.valid_exe !== 1'b1) begin
      errors++; $display("FAIL nop_word: got ctl=%0d ill=%b vld=%b want 0 0 1",
                         bus.alucontrol_exe, bus.illegal_exe, bus.valid_exe);
    end
  endtask

  task automatic test_reset_mid();
    rand_instr();
    tick();
    rand_instr(); bus.stall = 1; rst = 1;
    tick();
    checks++;
    if (observed() !== bubble() || bus.valid_exe !== 1'b0) begin
      errors++; $display("FAIL reset_mid_stall: got %h want %h", observed(), bubble());
    end
    rst = 0; bus.stall = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_instr();
      bus.valid_id = ($urandom_range(0, 4) != 0);
      bus.stall    = ($urandom_range(0, 3) == 0);
      bus.flush    = ($urandom_range(0, 9) == 0);
      rst          = ($urandom_range(0, 49) == 0);
      tick();
      checks++;
      if (observed() !== model) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", i, observed(), model);
      end
    end
    rst = 0;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    model = bubble();
    test_reset();
    test_add();
    test_imm();
    test_fwd();
    test_stall_flush();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
